// File: rtl/apb_slv_pkg.sv
// Shared types and register-map constants for the APB register-file completer.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int IDX_ID   = 0;
  localparam int IDX_WCNT = 1;
  localparam int NUM_REGS = 16;

endpackage

// File: rtl/apb_slave_regs.sv
// APB completer with a 16-word register file: read-only ID, committed-write counter,
// fixed wait-state insertion and pslverr on illegal accesses.
module apb_slave_regs
  import apb_slv_pkg::*;
#(
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h4150_4231
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_check
    $error("apb_slave_regs: WAIT_STATES must be in 0..15");
  end

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  idx_q;
  logic        err_q;
  logic [31:0] wcnt;
  logic [31:0] regs [NUM_REGS];

  logic [3:0]  idx_in;
  logic        addr_ok, err_in;
  logic        latch, load_rsp, commit;
  logic [3:0]  rsp_idx;
  logic        rsp_err;
  logic [31:0] rd_word;

  assign idx_in  = paddr[5:2];
  assign addr_ok = (paddr[31:6] == '0) && (paddr[1:0] == 2'b00);
  assign err_in  = !addr_ok ||
                   (pwrite && (idx_in == 4'(IDX_ID) || idx_in == 4'(IDX_WCNT)));

  // Response data comes from the live bus decode when leaving IDLE directly,
  // otherwise from the copy latched at SETUP.
  always_comb begin
    rsp_idx = (state == ST_IDLE) ? idx_in : idx_q;
    rsp_err = (state == ST_IDLE) ? err_in : err_q;
    rd_word = regs[rsp_idx];
    if (rsp_idx == 4'(IDX_ID))   rd_word = ID_VALUE;
    if (rsp_idx == 4'(IDX_WCNT)) rd_word = wcnt;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
    load_rsp = 1'b0;
    commit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = ST_RESP;
            load_rsp = 1'b1;
          end else begin
            cnt_nx   = 4'(WAIT_STATES);
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nx = ST_RESP;
            load_rsp = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
        commit   = psel && penable && pwrite && !err_q;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wcnt    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pready  <= load_rsp;
      pslverr <= load_rsp && rsp_err;
      if (load_rsp) prdata <= rsp_err ? '0 : rd_word;
      if (latch) begin
        idx_q <= idx_in;
        err_q <= err_in;
      end
      // err_q already excludes indices 0 and 1, so regs[0..1] stay zero.
      if (commit) begin
        regs[idx_q] <= pwdata;
        wcnt        <= wcnt + 32'd1;
      end
    end
  end

endmodule
